// File: rtl/servo_dir_ctrl_if.sv
// Sensor-sample input and PWM-stage direction/feedback bundle
// for the servo direction-decision stage.
interface servo_dir_ctrl_if #(
  parameter int SW = 12
);
  logic [SW-1:0] SENS_A;
  logic [SW-1:0] SENS_B;
  logic          SENS_VALID;
  logic [31:0]   PULSE_WIDTH;
  logic [1:0]    DIR;
  logic          EN;
  logic          BUSY;

  modport master (
    output SENS_A, SENS_B, SENS_VALID, PULSE_WIDTH,
    input  DIR, EN, BUSY
  );

  modport slave (
    input  SENS_A, SENS_B, SENS_VALID, PULSE_WIDTH,
    output DIR, EN, BUSY
  );
endinterface

// File: rtl/servo_dir_ctrl.sv
// Servo direction decision with deadband, confirmation, move timeout and settle.
// Optional 4-sample moving average per sensor: define SERVO_DIR_AVG_EN.
module servo_dir_ctrl #(
  parameter int SW       = 12,
  parameter int DEADBAND = 40,
  parameter int CONFIRM  = 3,
  parameter int MAX_MOVE = 2000000,
  parameter int SETTLE   = 500000,
  parameter int MIN_PW   = 500,
  parameter int MAX_PW   = 2500
) (
  input logic             CLK,
  input logic             RST,
  servo_dir_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_CW,
    MOVE_CCW,
    SETTLE_ST
  } state_t;

  localparam logic [1:0] D_HOLD = 2'b00;
  localparam logic [1:0] D_CW   = 2'b01;
  localparam logic [1:0] D_CCW  = 2'b10;

  localparam int TMAX = (MAX_MOVE > SETTLE) ? MAX_MOVE : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] MOVE_END   = TW'(MAX_MOVE - 1);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE - 1);
  localparam logic [3:0]    CONF       = 4'(CONFIRM);
  localparam logic [31:0]   PW_MAX     = 32'(MAX_PW);
  localparam logic [31:0]   PW_MIN     = 32'(MIN_PW);
  localparam logic signed [SW:0] DB    = DEADBAND[SW:0];

  logic [SW-1:0] a_eff;
  logic [SW-1:0] b_eff;
  logic          v_eff;

`ifdef SERVO_DIR_AVG_EN
  logic [3:0][SW-1:0] hist_a;
  logic [3:0][SW-1:0] hist_b;
  logic [SW+1:0]      sum_a;
  logic [SW+1:0]      sum_b;
  logic               avg_v;

  // Running sum: add the newest sample, drop the one leaving the window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_a <= '0;
      hist_b <= '0;
      sum_a  <= '0;
      sum_b  <= '0;
      avg_v  <= 1'b0;
    end else begin
      avg_v <= bus.SENS_VALID;
      if (bus.SENS_VALID) begin
        hist_a <= {hist_a[2:0], bus.SENS_A};
        hist_b <= {hist_b[2:0], bus.SENS_B};
        sum_a  <= sum_a + {2'b00, bus.SENS_A}
                - {2'b00, hist_a[3]};
        sum_b  <= sum_b + {2'b00, bus.SENS_B}
                - {2'b00, hist_b[3]};
      end
    end
  end

  assign a_eff = sum_a[SW+1:2];
  assign b_eff = sum_b[SW+1:2];
  assign v_eff = avg_v;
`else
  assign a_eff = bus.SENS_A;
  assign b_eff = bus.SENS_B;
  assign v_eff = bus.SENS_VALID;
`endif

  logic signed [SW:0] diff;
  logic [1:0]         want;
  logic [1:0]         dec;
  logic               at_max;
  logic               at_min;

  assign diff   = $signed({1'b0, a_eff})
                - $signed({1'b0, b_eff});
  assign at_max = bus.PULSE_WIDTH >= PW_MAX;
  assign at_min = bus.PULSE_WIDTH <= PW_MIN;

  always_comb begin
    want = D_HOLD;
    if (diff > DB) begin
      want = D_CW;
    end else if (diff < -DB) begin
      want = D_CCW;
    end
    dec = want;
    if (want == D_CW && at_max) begin
      dec = D_HOLD;
    end
    if (want == D_CCW && at_min) begin
      dec = D_HOLD;
    end
  end

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [1:0]    last, last_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [1:0]    dir, dir_n;
  logic          busy, busy_n;
  logic          en;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    tmr_n   = tmr + 1'b1;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (v_eff) begin
          last_n = dec;
          if (dec != D_HOLD && dec == last) begin
            cnt_n = (cnt == 4'hf) ? cnt : cnt + 4'd1;
          end else begin
            cnt_n = (dec != D_HOLD) ? 4'd1 : 4'd0;
          end
          if (dec != D_HOLD && cnt_n == CONF) begin
            state_n = (dec == D_CW) ? MOVE_CW : MOVE_CCW;
            cnt_n   = '0;
          end
        end
      end
      MOVE_CW: begin
        if (at_max || (v_eff && dec != D_CW)
            || tmr == MOVE_END) begin
          state_n = SETTLE_ST;
          tmr_n   = '0;
        end
      end
      MOVE_CCW: begin
        if (at_min || (v_eff && dec != D_CCW)
            || tmr == MOVE_END) begin
          state_n = SETTLE_ST;
          tmr_n   = '0;
        end
      end
      SETTLE_ST: begin
        if (tmr == SETTLE_END) begin
          state_n = IDLE;
          tmr_n   = '0;
          cnt_n   = '0;
          last_n  = D_HOLD;
        end
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
        cnt_n   = '0;
        last_n  = D_HOLD;
      end
    endcase
  end

  // Outputs are registered from the next state, giving 1-cycle latency.
  always_comb begin
    dir_n  = D_HOLD;
    busy_n = 1'b0;
    unique case (state_n)
      MOVE_CW: begin
        dir_n  = D_CW;
        busy_n = 1'b1;
      end
      MOVE_CCW: begin
        dir_n  = D_CCW;
        busy_n = 1'b1;
      end
      SETTLE_ST: busy_n = 1'b1;
      default:   busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= D_HOLD;
      tmr   <= '0;
      dir   <= D_HOLD;
      busy  <= 1'b0;
      en    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      tmr   <= tmr_n;
      dir   <= dir_n;
      busy  <= busy_n;
      en    <= 1'b1;
    end
  end

  assign bus.DIR  = dir;
  assign bus.BUSY = busy;
  assign bus.EN   = en;

endmodule
